// File: rtl/tx_pattern_drv_ctrl.sv
// TX pattern source (per-lane seedable LFSRs, fixed/clock/inverted-PRBS words) plus driver-strength code control.
// Optional build macro TX_DRV_RAMP_EN: slew-ramp the N/P codes one step per RAMP_DIV cycles instead of jumping.
module tx_pattern_drv_ctrl #(
    parameter int WIDTH    = 16,
    parameter int PRBS_LEN = 32,
    parameter int NSLICE   = 40,
    parameter int RAMP_DIV = 4,
    localparam int CODE_W  = $clog2(NSLICE + 1),
    localparam int SIDX_W  = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [1:0]          mode,
    input  logic [PRBS_LEN-1:0] eqn,
    input  logic [WIDTH-1:0]    fixed_pat,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic [SIDX_W-1:0]   seed_idx,
    input  logic [PRBS_LEN-1:0] seed_data,
    input  logic                inj_err,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    input  logic [CODE_W-1:0]   tgt_n,
    input  logic [CODE_W-1:0]   tgt_p,
    output logic [CODE_W-1:0]   code_n,
    output logic [CODE_W-1:0]   code_p,
    output logic [NSLICE-1:0]   therm_n,
    output logic [NSLICE-1:0]   therm_p,
    output logic                drv_busy
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic                  w_gen;
    logic [PRBS_LEN-1:0]   r_lfsr [WIDTH];
    logic [WIDTH-1:0]      w_fb;
    logic [WIDTH-1:0]      w_word;
    logic                  w_step;
    logic                  w_seed_wr;
    logic                  r_inj_q;
    logic                  w_inj_rise;
    logic [WIDTH-1:0]      r_dout;
    logic                  r_dout_valid;
    logic [CODE_W-1:0]     w_tgt_n, w_tgt_p;
    logic [CODE_W-1:0]     r_code_n, r_code_p;
    logic [CODE_W-1:0]     w_code_n_nxt, w_code_p_nxt;
    logic [NSLICE-1:0]     r_therm_n, r_therm_p;

    function automatic logic [CODE_W-1:0] f_clamp(input logic [CODE_W-1:0] t);
        return (int'(t) > NSLICE) ? CODE_W'(NSLICE) : t;
    endfunction

    function automatic logic [NSLICE-1:0] f_therm(input logic [CODE_W-1:0] c);
        logic [NSLICE-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < NSLICE; i++) t[i] = (i < int'(c));
        return t;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (run)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!run) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Words are produced at the same edge that enters/stays in RUN, so the first word follows run by one cycle.
    always_comb begin
        seed_ready = (r_state == ST_IDLE);
        w_gen      = (w_state_nxt == ST_RUN);
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) w_fb[i] = ^(r_lfsr[i] & eqn);
    end

    always_comb begin
        case (mode)
            2'd0:    w_word = w_fb;
            2'd1:    w_word = fixed_pat;
            2'd2:    w_word = {(WIDTH/2){2'b10}};
            default: w_word = ~w_fb;
        endcase
    end

    assign w_step     = w_gen && ((mode == 2'd0) || (mode == 2'd3));
    assign w_seed_wr  = seed_valid && seed_ready && (int'(seed_idx) < WIDTH);
    assign w_inj_rise = inj_err && !r_inj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) r_lfsr[i] <= '1;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (w_seed_wr && (seed_idx == SIDX_W'(i)))
                    r_lfsr[i] <= (seed_data == '0) ? PRBS_LEN'(1) : seed_data;
                else if (w_step)
                    r_lfsr[i] <= {r_lfsr[i][PRBS_LEN-2:0], w_fb[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inj_q      <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_inj_q <= inj_err;
            if (w_gen) begin
                r_dout       <= w_word ^ {{(WIDTH-1){1'b0}}, w_inj_rise};
                r_dout_valid <= 1'b1;
            end else begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign w_tgt_n = f_clamp(tgt_n);
    assign w_tgt_p = f_clamp(tgt_p);

`ifdef TX_DRV_RAMP_EN
    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick   = (int'(r_div) == RAMP_DIV - 1);
    assign drv_busy = (r_code_n != w_tgt_n) || (r_code_p != w_tgt_p);

    // Shared divider: parked at zero while both codes are settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_div <= '0;
        else if (!drv_busy || w_tick) r_div <= '0;
        else                       r_div <= r_div + 1'b1;
    end

    always_comb begin
        w_code_n_nxt = r_code_n;
        w_code_p_nxt = r_code_p;
        if (w_tick && drv_busy) begin
            if (r_code_n < w_tgt_n)      w_code_n_nxt = r_code_n + 1'b1;
            else if (r_code_n > w_tgt_n) w_code_n_nxt = r_code_n - 1'b1;
            if (r_code_p < w_tgt_p)      w_code_p_nxt = r_code_p + 1'b1;
            else if (r_code_p > w_tgt_p) w_code_p_nxt = r_code_p - 1'b1;
        end
    end
`else
    assign drv_busy = 1'b0;

    always_comb begin
        w_code_n_nxt = w_tgt_n;
        w_code_p_nxt = w_tgt_p;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_n  <= '0;
            r_code_p  <= '0;
            r_therm_n <= '0;
            r_therm_p <= '0;
        end else begin
            r_code_n  <= w_code_n_nxt;
            r_code_p  <= w_code_p_nxt;
            r_therm_n <= f_therm(w_code_n_nxt);
            r_therm_p <= f_therm(w_code_p_nxt);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign code_n     = r_code_n;
    assign code_p     = r_code_p;
    assign therm_n    = r_therm_n;
    assign therm_p    = r_therm_p;

endmodule

// File: tb/tb_tx_pattern_drv_ctrl.sv
// Scoreboard bench for tx_pattern_drv_ctrl: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_tx_pattern_drv_ctrl;
    localparam int WIDTH = 16, PRBS_LEN = 32, NSLICE = 40, RAMP_DIV = 4, CODE_W = 6;

    logic                clk, rst, run, seed_valid, seed_ready, inj_err, dout_valid, drv_busy;
    logic [1:0]          mode;
    logic [PRBS_LEN-1:0] eqn, seed_data;
    logic [WIDTH-1:0]    fixed_pat, dout;
    logic [3:0]          seed_idx;
    logic [CODE_W-1:0]   tgt_n, tgt_p, code_n, code_p;
    logic [NSLICE-1:0]   therm_n, therm_p;

    tx_pattern_drv_ctrl #(.WIDTH(WIDTH), .PRBS_LEN(PRBS_LEN), .NSLICE(NSLICE), .RAMP_DIV(RAMP_DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .mode(mode), .eqn(eqn), .fixed_pat(fixed_pat),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_idx(seed_idx), .seed_data(seed_data),
        .inj_err(inj_err), .dout(dout), .dout_valid(dout_valid), .tgt_n(tgt_n), .tgt_p(tgt_p),
        .code_n(code_n), .code_p(code_p), .therm_n(therm_n), .therm_p(therm_p), .drv_busy(drv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [WIDTH-1:0]    q_exp [$];
    logic [PRBS_LEN-1:0] m_lfsr [WIDTH];
    logic                m_inj_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) m_lfsr[i] = '1;
        m_inj_q = 1'b0;
    endtask

    // One clock: when run is sampled high, compute the expected word from the reference LFSRs and queue it.
    task automatic cyc();
        logic [WIDTH-1:0] fb, w;
        if (run) begin
            for (int i = 0; i < WIDTH; i++) fb[i] = ^(m_lfsr[i] & eqn);
            case (mode)
                2'd0: w = fb;
                2'd1: w = fixed_pat;
                2'd2: w = 16'hAAAA;
                default: w = ~fb;
            endcase
            if (inj_err && !m_inj_q) w[0] = ~w[0];
            if (mode == 2'd0 || mode == 2'd3)
                for (int i = 0; i < WIDTH; i++) m_lfsr[i] = {m_lfsr[i][PRBS_LEN-2:0], fb[i]};
            q_exp.push_back(w);
        end
        m_inj_q = inj_err;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (dout_valid) begin
            n_cmp++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", dout);
            end else begin
                logic [WIDTH-1:0] e;
                e = q_exp.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL word: got %0h expected %0h", dout, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit hit;
        rst = 1'b1; run = 0; mode = 0; eqn = 32'h100002; fixed_pat = '0;
        seed_valid = 0; seed_idx = 0; seed_data = '0; inj_err = 0; tgt_n = 0; tgt_p = 0;
        model_reset();
        #3;
        chk("rst_dout", 64'(dout), 0);
        chk("rst_valid", 64'(dout_valid), 0);
        chk("rst_seed_ready", 64'(seed_ready), 1);
        chk("rst_code_n", 64'(code_n), 0);
        chk("rst_therm_n", 64'(therm_n), 0);
        chk("rst_busy", 64'(drv_busy), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Seed lane0 = 2 and lane3 = 0 (stored as 1) while idle
        seed_valid = 1; seed_idx = 0; seed_data = 32'h2; cyc(); m_lfsr[0] = 32'h2;
        seed_idx = 3; seed_data = 32'h0; cyc(); m_lfsr[3] = 32'h1;
        seed_valid = 0;
        chk("idle_seed_ready", 64'(seed_ready), 1);

        mode = 0; run = 1;
        cyc();
        chk("first_valid", 64'(dout_valid), 1);
        chk("first_word", 64'(dout), 64'h0001);
        repeat (6) cyc();

        // Seed attempt while running must be refused and leave the sequence intact
        seed_valid = 1; seed_idx = 0; seed_data = 32'hDEAD_BEEF;
        chk("run_seed_ready", 64'(seed_ready), 0);
        cyc(); seed_valid = 0;
        repeat (3) cyc();

        mode = 3; repeat (3) cyc();
        mode = 2; cyc(); chk("clk_pat", 64'(dout), 64'hAAAA); repeat (2) cyc();
        mode = 1; fixed_pat = 16'h1234; cyc(); chk("fixed_pat", 64'(dout), 64'h1234); cyc();

        run = 0; cyc();
        chk("idle_valid", 64'(dout_valid), 0);
        chk("idle_dout", 64'(dout), 0);
        inj_err = 1; cyc(); inj_err = 0;
        run = 1; mode = 0; repeat (4) cyc();

        // Error injection: held high gives one error, separate pulses give one each
        mode = 1; fixed_pat = 16'h0000;
        inj_err = 1; cyc(); chk("inj_first", 64'(dout), 64'h0001);
        repeat (4) cyc();
        inj_err = 0; cyc();
        inj_err = 1; cyc(); inj_err = 0; cyc();
        inj_err = 1; cyc(); inj_err = 0; cyc();
        run = 0; cyc(); cyc();

`ifdef TX_DRV_RAMP_EN
        tgt_n = 5; cnt = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(); cnt++;
            if (k == 0) chk("ramp_busy", 64'(drv_busy), 1);
            if (code_n == 6'd5) break;
        end
        chk("ramp_cycles", 64'(cnt), 20);
        chk("ramp_settled_busy", 64'(drv_busy), 0);
        tgt_n = 63; tgt_p = 2;
        for (int k = 0; k < 500; k++) begin
            if (!drv_busy) break;
            cyc();
        end
        chk("clamp_code_n", 64'(code_n), 40);
        chk("clamp_therm_n", 64'(therm_n), 64'hFF_FFFF_FFFF);
        chk("code_p", 64'(code_p), 2);
        chk("therm_p", 64'(therm_p), 64'h3);
        tgt_n = 0; run = 1; mode = 1; fixed_pat = 16'h0F0F; hit = 0;
        for (int k = 0; k < 400; k++) begin
            cyc();
            if (code_n == 6'd3) begin hit = 1; break; end
        end
        chk("mid_ramp_reached", 64'(hit), 1);
`else
        tgt_n = 63; tgt_p = 5; cyc();
        chk("clamp_code_n", 64'(code_n), 40);
        chk("clamp_therm_n", 64'(therm_n), 64'hFF_FFFF_FFFF);
        chk("code_p", 64'(code_p), 5);
        chk("therm_p", 64'(therm_p), 64'h1F);
        chk("busy_const", 64'(drv_busy), 0);
        tgt_n = 3; run = 1; mode = 1; fixed_pat = 16'h0F0F; cyc();
        chk("code_n3", 64'(code_n), 3);
        chk("therm_n3", 64'(therm_n), 64'h7);
`endif
        // Asynchronous reset between edges while running
        @(negedge clk); #1;
        rst = 1'b1; #1;
        model_reset();
        chk("arst_code_n", 64'(code_n), 0);
        chk("arst_therm_n", 64'(therm_n), 0);
        chk("arst_dout", 64'(dout), 0);
        chk("arst_valid", 64'(dout_valid), 0);
        @(posedge clk); #1; rst = 1'b0;
        tgt_n = 0; tgt_p = 0;
        run = 1; mode = 3;
        cyc(); chk("restart_word", 64'(dout), 64'hFFFF);
        mode = 0; repeat (4) cyc();
        run = 0; cyc(); cyc();
        chk("queue_drained", 64'(q_exp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
